pl2_exec: RTL

PL2_EXEC -- requirements
Module: pl2_exec

---
 rtl/pl2_exec.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pl2_exec.sv
// pl2_exec: execute stage of a two-stage RV32IM pipeline.
// It combines a single-cycle ALU, a single-cycle multiplier and an optional
// iterative restoring divider. Build with M_EXT_DIV_EN defined to include
// the divider. Without it, DIV/DIVU/REM/REMU return 0 and o_stall is tied low.

package pl2_exec_pkg;
  typedef enum logic [1:0] {
    L_S_BYTE = 2'd0,
    L_S_HALF = 2'd1,
    L_S_WORD = 2'd2
  } l_s_sel_t;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;
endpackage

module pl2_exec
  import pl2_exec_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [3:0]  i_alu_op,
  input  logic        i_is_muldiv,
  input  logic [2:0]  i_muldiv_op,
  input  logic        i_mem_wr_en,
  input  logic        i_mem_rd_en,
  input  logic [31:0] i_mem_wr_val,
  input  l_s_sel_t    i_l_s_sel_val,
  input  logic [4:0]  i_rd_addr,
  output logic [31:0] o_alu_out_val,
  output logic        o_mem_wr_en,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_wr_val,
  output l_s_sel_t    o_l_s_sel_val,
  output logic [4:0]  o_ff_addr,
  output logic        o_stall
);

  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        mul_a_sgn;
  logic        mul_b_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] mul_res;
  logic [31:0] div_res;
  logic [31:0] exec_res;
  logic        accept;

  assign shamt = i_op_b[4:0];

  // ALU result for the integer base operations.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = 32'd0;
    case (i_alu_op)
      ALU_ADD:    alu_res = i_op_a + i_op_b;
      ALU_SUB:    alu_res = i_op_a - i_op_b;
      ALU_SLL:    alu_res = i_op_a << shamt;
      ALU_SLT:    alu_res = {31'd0, $signed(i_op_a) < $signed(i_op_b)};
      ALU_SLTU:   alu_res = {31'd0, i_op_a < i_op_b};
      ALU_XOR:    alu_res = i_op_a ^ i_op_b;
      ALU_SRL:    alu_res = i_op_a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(i_op_a) >>> shamt);
      ALU_OR:     alu_res = i_op_a | i_op_b;
      ALU_AND:    alu_res = i_op_a & i_op_b;
      ALU_PASS_B: alu_res = i_op_b;
      default:    alu_res = 32'd0;
    endcase
  end

  // Multiplier: sign-extend each operand to 64 bits as the op requires; the
  // low 64 bits of the product are then exact for every signedness mix.
  always_comb begin
    mul_a_sgn = (i_muldiv_op[1:0] != 2'd3);
    mul_b_sgn = (i_muldiv_op[1] == 1'b0);
    mul_a     = {{32{mul_a_sgn & i_op_a[31]}}, i_op_a};
    mul_b     = {{32{mul_b_sgn & i_op_b[31]}}, i_op_b};
    product   = mul_a * mul_b;
    mul_res   = (i_muldiv_op[1:0] == 2'd0) ? product[31:0] : product[63:32];
  end

`ifdef M_EXT_DIV_EN
  typedef enum logic {IDLE, BUSY} div_state_t;

  div_state_t  state;
  div_state_t  state_next;
  logic [4:0]  count;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic        is_div;
  logic        div_signed;
  logic        div_is_rem;
  logic        div_special;
  logic        div_start;
  logic [31:0] div_special_res;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] rem_shift;
  logic        step_ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Decode the divide op and resolve the cases that finish in one cycle.
  always_comb begin
    is_div      = i_is_muldiv & i_muldiv_op[2];
    div_signed  = ~i_muldiv_op[0];
    div_is_rem  = i_muldiv_op[1];
    div_special = (i_op_b == 32'd0) ||
                  (div_signed && i_op_a == 32'h8000_0000 && i_op_b == 32'hFFFF_FFFF);
    div_start   = i_valid & is_div & ~div_special;
    if (i_op_b == 32'd0)
      div_special_res = div_is_rem ? i_op_a : 32'hFFFF_FFFF;
    else
      div_special_res = div_is_rem ? 32'd0 : 32'h8000_0000;
    a_abs = (div_signed && i_op_a[31]) ? (32'd0 - i_op_a) : i_op_a;
    b_abs = (div_signed && i_op_b[31]) ? (32'd0 - i_op_b) : i_op_b;
  end

  // One restoring step: shift the next dividend bit in and subtract if it fits.
  // Bit 32 of the shifted remainder alone already proves it exceeds the divisor.
  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    step_ge   = rem_shift[32] | (rem_shift[31:0] >= dvs_q);
    rem_step  = step_ge ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
    quo_step  = {quo_q[30:0], step_ge};
    quo_fix   = neg_quo_q ? (32'd0 - quo_step) : quo_step;
    rem_fix   = neg_rem_q ? (32'd0 - rem_step) : rem_step;
    if (state == BUSY)
      div_res = div_is_rem ? rem_fix : quo_fix;
    else
      div_res = div_special_res;
  end

  // Divider next state and stall; the last step (count 31) runs unstalled.
  always_comb begin
    state_next = state;
    o_stall    = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          o_stall    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count == 5'd31) state_next = IDLE;
        else                o_stall    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider control state; reset abandons any divide in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      count <= 5'd0;
    end else begin
      state <= state_next;
      if (state == BUSY) count <= count + 5'd1;
      else               count <= 5'd0;
    end
  end

  // Divider datapath; never observed outside BUSY, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (state == IDLE) begin
      rem_q     <= 32'd0;
      quo_q     <= a_abs;
      dvs_q     <= b_abs;
      neg_quo_q <= div_signed & (i_op_a[31] ^ i_op_b[31]);
      neg_rem_q <= div_signed & i_op_a[31];
    end else begin
      rem_q <= rem_step;
      quo_q <= quo_step;
    end
  end
`else
  assign div_res = 32'd0;
  assign o_stall = 1'b0;
`endif

  assign exec_res = i_is_muldiv ? (i_muldiv_op[2] ? div_res : mul_res) : alu_res;
  assign accept   = i_valid & ~o_stall;

  // Output register: a bubble on reset, on an idle slot or while stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst || !accept) begin
      o_alu_out_val <= 32'd0;
      o_mem_wr_en   <= 1'b0;
      o_mem_rd_en   <= 1'b0;
      o_mem_wr_val  <= 32'd0;
      o_l_s_sel_val <= L_S_BYTE;
      o_ff_addr     <= 5'd0;
    end else begin
      o_alu_out_val <= exec_res;
      o_mem_wr_en   <= i_mem_wr_en;
      o_mem_rd_en   <= i_mem_rd_en;
      o_mem_wr_val  <= i_mem_wr_val;
      o_l_s_sel_val <= i_l_s_sel_val;
      o_ff_addr     <= i_rd_addr;
    end
  end

endmodule
